// File: rtl/mul8_seq.sv
// Sequential unsigned shift-and-add multiplier driving an external N-bit ripple adder.
// Optional MUL8_ZERO_SKIP_EN: a zero operand on start bypasses RUN and finishes in one cycle.
module mul8_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [N-1:0]   add_x,
    output logic [N-1:0]   add_y,
    input  logic [N-1:0]   add_s,
    input  logic           add_c
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_m;
    logic [N-1:0]   r_p_hi;
    logic [N-1:0]   r_p_lo;
    logic [CW-1:0]  r_cnt;
    logic           w_accept;
    logic           w_last;
    logic           w_skip;

    assign w_last = (r_cnt == CW'(N - 1));

`ifdef MUL8_ZERO_SKIP_EN
    assign w_skip = (a == '0) || (b == '0);
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Adder operands come only from registered state so the adder stays quiet outside RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        ready       = 1'b0;
        done        = 1'b0;
        add_x       = '0;
        add_y       = '0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_skip ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                add_x = r_p_hi;
                add_y = r_p_lo[0] ? r_m : '0;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_skip ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Carry-out becomes the new MSB; the sum LSB shifts down into the multiplier half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m     <= '0;
            r_p_hi  <= '0;
            r_p_lo  <= '0;
            r_cnt   <= '0;
            product <= '0;
        end else if (w_accept) begin
            r_m    <= a;
            r_p_lo <= b;
            r_p_hi <= '0;
            r_cnt  <= '0;
            if (w_skip) product <= '0;
        end else if (r_state == S_RUN) begin
            r_p_hi <= {add_c, add_s[N-1:1]};
            r_p_lo <= {add_s[0], r_p_lo[N-1:1]};
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) product <= {add_c, add_s, r_p_lo[N-1:1]};
        end
    end

endmodule
